ysyx_23060191_ifu: RTL and testbench
====================================

Name: ysyx_23060191_ifu

Overview:
Instruction fetch unit: the initiator side of the instruction-memory interface. Holds the PC, issues word fetch requests to the instruction memory, and captures the returned instruction into a one-entry output buffer. Hands the instruction to decode over a valid/ready handshake. Accepts PC redirects (branch/jump/trap) from execute and squashes in-flight or buffered fetches.

Parameters:
CPU_WIDTH, 32, datapath/address width
RESET_PC, 32'h8000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, instruction emitted with a misalign fault (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  CPU_WIDTH  fetch address (= pc)
imem_rsp_valid  in  1  response valid, one pulse per accepted request
imem_rsp_data  in  CPU_WIDTH  fetched instruction
redirect_valid  in  1  load new PC, squash current fetch
redirect_pc  in  CPU_WIDTH  redirect target
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  CPU_WIDTH  instruction word
inst_pc  out  CPU_WIDTH  PC of inst
inst_misaligned  out  1  inst_pc[1:0]!=0; inst = NOP_INST

Behaviour:
- Registers: pc, state, kill, inst/inst_pc/inst_misaligned buffer. All updates are on the rising edge of clk.
- Reset, synchronous and dominant over every other input in any state: pc<=RESET_PC, state<=S_REQ, kill<=0, buffer<=0.
- While rst=1: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_misaligned=0.
- States: S_REQ (issue), S_WAIT (request accepted, awaiting response), S_OUT (buffer full).
- Outputs decode from the registered state. imem_req_valid = (state==S_REQ) && !redirect_valid && pc[1:0]==0. imem_req_addr = pc. inst_valid = (state==S_OUT).
- At most one outstanding request.
- S_REQ:
  - redirect_valid: pc<=redirect_pc, stay.
  - Else if pc[1:0]!=0: load buffer {NOP_INST, pc, misaligned=1}, go to S_OUT. No memory request is issued.
  - Else if imem_req_ready: go to S_WAIT.
  - Else hold; request stays asserted with a stable address.
- S_WAIT:
  - imem_rsp_valid && !kill && !redirect_valid: buffer<={imem_rsp_data, pc, 0}, pc<=pc+4 (modulo 2^CPU_WIDTH), go to S_OUT.
  - imem_rsp_valid && (kill || redirect_valid): discard the response, kill<=0, go to S_REQ. If redirect_valid, pc<=redirect_pc.
  - !imem_rsp_valid && redirect_valid: pc<=redirect_pc, kill<=1, stay.
  - A later redirect while kill=1 overwrites pc again.
- S_OUT:
  - inst_ready: handshake completes, go to S_REQ. If redirect_valid in the same cycle, pc<=redirect_pc; the instruction still counts as delivered.
  - redirect_valid && !inst_ready: drop the buffer, pc<=redirect_pc, go to S_REQ.
  - Else hold. inst/inst_pc/inst_misaligned stay stable while inst_valid && !inst_ready.
- For a misaligned buffer entry, pc is not advanced; only a redirect or reset recovers.
- imem_rsp_valid in S_REQ or S_OUT is a protocol violation: ignored, flagged by a bench assertion.
- Latency with ready memory (1-cycle response) and ready decode: request cycle N, response N+1, inst_valid N+2, next request N+3. Throughput is 1 instruction per 3 cycles; this is acceptable for the single-cycle bring-up core.
- Redirect takes effect on the next request cycle. A stale instruction is never presented after the redirect cycle.

Decomposition:
- Shared defines file: CPU_WIDTH, RESET_PC, NOP encoding, and the state encodings (2-bit localparams S_REQ=0, S_WAIT=1, S_OUT=2).
- No sub-module needed. The PC register and next-PC mux stay inline.

Test Plan:
- Reset, memory ready with 1-cycle response, decode always ready: requests to 0x8000_0000, 0x8000_0004, 0x8000_0008 in that order. inst_pc matches each address; inst equals the programmed addi words.
- Decode inst_ready low for 5 cycles in S_OUT: inst and inst_pc stable, no new imem request issued; one delivery on release.
- Redirect to 0x8000_0100 while in S_WAIT, response arrives 3 cycles later: that response is discarded. Next request is 0x8000_0100; the inst_pc delivered is 0x8000_0100.
- Redirect coincident with imem_rsp_valid in S_WAIT: response dropped, next imem_req_addr = redirect_pc. Also redirect with inst_ready in S_OUT: instruction delivered once, next fetch at target.
- Redirect to 0x8000_0102: no memory request issued. inst_valid=1, inst=0x0000_0013, inst_misaligned=1, inst_pc=0x8000_0102; held until a new redirect.
- rst asserted in S_WAIT and in S_OUT: next cycle state S_REQ, outputs zero during rst, first request after release at 0x8000_0000. A late response during rst is ignored.

Source files
------------

// File: rtl/ysyx_23060191_ifu_pkg.sv
// Shared constants for the instruction fetch unit: datapath width, reset PC,
// the NOP emitted for misaligned fetches, and the fetch FSM state encodings.
// Latency: n/a (constants only). Backpressure: n/a.
package ysyx_23060191_ifu_pkg;

    localparam int                   CPU_WIDTH = 32;
    localparam logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000;
    // addi x0, x0, 0
    localparam logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013;

    // Fetch FSM states
    localparam logic [1:0] S_REQ  = 2'd0;   // issue a request at pc
    localparam logic [1:0] S_WAIT = 2'd1;   // request accepted, awaiting response
    localparam logic [1:0] S_OUT  = 2'd2;   // output buffer full, offered to decode

    function automatic logic is_misaligned(input logic [CPU_WIDTH-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: holds pc, issues one word fetch at a time, buffers the result for decode.
// Latency: request cycle N, response N+1, inst_valid N+2, next request N+3 (1 inst / 3 cycles).
// Backpressure: buffer holds stable while inst_ready is low; no new request until it drains.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request to instruction memory (addr = pc)
//   imem_rsp_valid/data              one response pulse per accepted request
//   redirect_valid/pc                new pc from execute; squashes in-flight/buffered fetch
//   inst_valid/ready, inst, inst_pc  instruction handed to decode
//   inst_misaligned                  inst_pc not word aligned, inst forced to NOP
module ysyx_23060191_ifu
    import ysyx_23060191_ifu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic                 inst_misaligned
);

    logic [CPU_WIDTH-1:0] pc;
    logic [1:0]           state;
    // Set when a redirect arrives while a request is outstanding: the
    // eventual response belongs to the old path and must be dropped.
    logic                 kill;
    logic [CPU_WIDTH-1:0] buf_inst;
    logic [CPU_WIDTH-1:0] buf_pc;
    logic                 buf_mis;

    // Outputs are forced quiet during reset so nothing leaks out of whatever
    // state the FSM happened to be in when reset was raised.
    assign imem_req_valid  = !rst && (state == S_REQ) && !redirect_valid && !is_misaligned(pc);
    assign imem_req_addr   = pc;
    assign inst_valid      = !rst && (state == S_OUT);
    assign inst            = rst ? '0 : buf_inst;
    assign inst_pc         = rst ? '0 : buf_pc;
    assign inst_misaligned = !rst && buf_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= S_REQ;
            kill     <= 1'b0;
            buf_inst <= '0;
            buf_pc   <= '0;
            buf_mis  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (is_misaligned(pc)) begin
                        // Never fetch a misaligned address; hand decode a NOP
                        // flagged as faulting. pc stays put until redirected.
                        buf_inst <= NOP_INST;
                        buf_pc   <= pc;
                        buf_mis  <= 1'b1;
                        state    <= S_OUT;
                    end else if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!kill && !redirect_valid) begin
                            buf_inst <= imem_rsp_data;
                            buf_pc   <= pc;
                            buf_mis  <= 1'b0;
                            pc       <= pc + CPU_WIDTH'(4);
                            state    <= S_OUT;
                        end else begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                            if (redirect_valid) begin
                                pc <= redirect_pc;
                            end
                        end
                    end else if (redirect_valid) begin
                        pc   <= redirect_pc;
                        kill <= 1'b1;
                    end
                end
                S_OUT: begin
                    // A redirect alongside inst_ready still delivers the
                    // buffered instruction; without inst_ready it is dropped.
                    if (inst_ready || redirect_valid) begin
                        state <= S_REQ;
                        if (redirect_valid) begin
                            pc <= redirect_pc;
                        end
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Self-checking bench for the instruction fetch unit: directed scenarios, then random traffic.
// Latency: n/a. Backpressure: bench drives inst_ready / imem_req_ready both ways.
// The bench plays the instruction memory and decode, and tracks fetch transactions in a model.
module tb_ysyx_23060191_ifu;
    import ysyx_23060191_ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_misaligned;

    always #5 clk = ~clk;

    ysyx_23060191_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_misaligned(inst_misaligned)
    );

    int passed = 0;
    int total  = 0;

    // Transaction-level model of the fetch stream.
    logic [31:0] exp_next = RESET_PC;  // address the next fetch must target
    bit          full     = 0;         // decode should currently see an instruction
    bit          outst    = 0;         // one request accepted, response not yet seen
    bit          stale    = 0;         // outstanding request was overtaken by a redirect
    logic [31:0] out_addr = '0;
    logic [31:0] b_inst   = '0;
    logic [31:0] b_pc     = '0;
    logic        b_mis    = 1'b0;
    int          dcount   = 0;
    logic [31:0] last_dpc = '0;

    // Program image: every word is "addi x1, x1, addr[13:2]".
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[13:2], 5'd1, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    // rsp_en only produces a response when a request is outstanding (or in
    // reset, to exercise a late response being ignored).
    task automatic cyc(input logic r, input logic rdy, input logic rsp_en,
                       input logic redir, input logic [31:0] rpc, input logic irdy);
        logic do_rsp;
        logic req_exp;
        @(negedge clk);
        do_rsp         = rsp_en && (outst || r);
        rst            = r;
        imem_req_ready = rdy;
        imem_rsp_valid = do_rsp;
        imem_rsp_data  = do_rsp ? memf(out_addr) : $urandom;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = irdy;
        #1;
        if (r) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_inst_valid", inst_valid, 0);
            chk("rst_inst", inst, 0);
            chk("rst_inst_pc", inst_pc, 0);
            chk("rst_misaligned", inst_misaligned, 0);
            full = 0; outst = 0; stale = 0; exp_next = RESET_PC;
        end else begin
            req_exp = !full && !outst && !redir && (exp_next[1:0] == 2'b00);
            chk("req_valid", imem_req_valid, req_exp);
            if (req_exp) chk("req_addr", imem_req_addr, exp_next);
            chk("inst_valid", inst_valid, full);
            if (full) begin
                chk("inst", inst, b_inst);
                chk("inst_pc", inst_pc, b_pc);
                chk("inst_misaligned", inst_misaligned, b_mis);
            end
            if (full) begin
                if (irdy) begin
                    dcount++;
                    last_dpc = b_pc;
                end
                if (irdy || redir) full = 0;
            end else if (outst) begin
                if (do_rsp) begin
                    outst = 0;
                    if (!stale && !redir) begin
                        full = 1; b_inst = memf(out_addr); b_pc = out_addr; b_mis = 0;
                        exp_next = out_addr + 32'd4;
                    end
                    stale = 0;
                end else if (redir) begin
                    stale = 1;
                end
            end else if (!redir) begin
                if (exp_next[1:0] != 2'b00) begin
                    full = 1; b_inst = NOP_INST; b_pc = exp_next; b_mis = 1;
                end else if (rdy) begin
                    outst = 1; out_addr = exp_next; stale = 0;
                end
            end
            if (redir) exp_next = rpc;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        // Reset
        cyc(1, 0, 0, 0, '0, 0);
        cyc(1, 0, 0, 0, '0, 0);

        // Streaming with ready memory and ready decode: three fetches
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, '0, 1);
        chk("stream_count", dcount, 3);
        chk("stream_last_pc", last_dpc, 32'h8000_0008);

        // Decode stalls 5 cycles with the buffer full
        cyc(0, 1, 0, 0, '0, 0);
        cyc(0, 1, 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, '0, 0);
        chk("stall_count", dcount, 3);
        cyc(0, 1, 0, 0, '0, 1);
        chk("stall_release", dcount, 4);

        // Redirect while waiting; old response arrives 3 cycles later
        cyc(0, 1, 0, 0, '0, 1);
        cyc(0, 1, 0, 1, 32'h8000_0100, 1);
        cyc(0, 1, 0, 0, '0, 1);
        cyc(0, 1, 0, 0, '0, 1);
        cyc(0, 1, 1, 0, '0, 1);
        chk("kill_count", dcount, 4);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, '0, 1);
        chk("kill_target_pc", last_dpc, 32'h8000_0100);

        // Redirect coincident with the response
        cyc(0, 1, 0, 0, '0, 1);
        cyc(0, 1, 1, 1, 32'h8000_0200, 1);
        cyc(0, 1, 1, 0, '0, 1);
        cyc(0, 1, 1, 0, '0, 1);
        // Redirect together with inst_ready: delivered once, then fetch target
        cyc(0, 1, 1, 1, 32'h8000_0300, 1);
        chk("redir_deliver_pc", last_dpc, 32'h8000_0200);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, '0, 1);
        chk("redir_target_pc", last_dpc, 32'h8000_0300);

        // Misaligned target: NOP with fault, held until the next redirect
        cyc(0, 1, 1, 1, 32'h8000_0102, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, '0, 0);
        cyc(0, 1, 1, 1, 32'h8000_0400, 0);
        chk("misalign_not_taken", last_dpc, 32'h8000_0300);

        // Reset in S_WAIT with a late response during reset
        cyc(0, 1, 0, 0, '0, 1);
        cyc(1, 0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, '0, 1);
        chk("rst_wait_pc", last_dpc, 32'h8000_0000);
        // Reset in S_OUT
        cyc(0, 1, 0, 0, '0, 0);
        cyc(0, 1, 1, 0, '0, 0);
        cyc(1, 0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, '0, 1);
        chk("rst_out_pc", last_dpc, 32'h8000_0000);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            tgt = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 3) == 0) tgt = tgt | $urandom_range(1, 3);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                tgt, $urandom_range(0, 2) != 0);
        end
        chk("random_progress", (dcount > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
